// File: rtl/contract_pkg.sv
// Shared types and constants for the contract-mode issue stepper.
package contract_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone,
    StFree
  } stepper_state_e;

  localparam int unsigned STEP_TIMEOUT_DEFAULT = 1024;

  // Record carries the widest supported count; the stepper uses the low CNT_W bits.
  localparam int unsigned STEP_CNT_W_MAX = 64;

  typedef struct packed {
    logic [STEP_CNT_W_MAX-1:0] issued;
    logic                      timeout;
  } step_done_t;

endpackage

// File: rtl/contract_step_watchdog.sv
// Stall watchdog: counts consecutive idle cycles, flags the increment that reaches the limit.
module contract_step_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic inc_i,
  output logic expired_o
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Asserted in the cycle whose increment brings the count to the limit.
  assign expired_o = inc_i && (count_q == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/contract_issue_stepper.sv
// Gates core issue to release exactly N instructions or free-run; returns a completion record.
// Optional lifetime stats build with macro CONTRACT_STEP_STATS_EN.
module contract_issue_stepper
  import contract_pkg::*;
#(
  parameter int unsigned CNT_W          = 32,
  parameter int unsigned TIMEOUT_CYCLES = STEP_TIMEOUT_DEFAULT
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             step_valid_i,
  output logic             step_ready_o,
  input  logic [CNT_W-1:0] step_count_i,
  input  logic             free_run_i,
  output logic             enable_issue_o,
  input  logic             issue_i,
  output logic             done_valid_o,
  input  logic             done_ready_i,
  output logic [CNT_W-1:0] done_issued_o,
  output logic             done_timeout_o,
  output logic             busy_o,
  output logic [63:0]      total_issued_o,
  output logic             stray_issue_o
);

  stepper_state_e   state_q, state_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [CNT_W-1:0] issued_q, issued_d;
  logic             timeout_q, timeout_d;
  logic             wd_clr, wd_inc, wd_expired;
  step_done_t       done_rec;
  logic             unused_rec_hi;

  contract_step_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (wd_clr),
    .inc_i    (wd_inc),
    .expired_o(wd_expired)
  );

  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    issued_d     = issued_q;
    timeout_d    = timeout_q;
    step_ready_o = 1'b0;
    wd_clr       = 1'b1;
    wd_inc       = 1'b0;
    unique case (state_q)
      StIdle: begin
        step_ready_o = !free_run_i;
        if (free_run_i) begin
          state_d = StFree;
        end else if (step_valid_i) begin
          remaining_d = step_count_i;
          issued_d    = '0;
          timeout_d   = 1'b0;
          state_d     = (step_count_i == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        if (issue_i) begin
          remaining_d = remaining_q - CNT_W'(1);
          if (issued_q != '1) begin
            issued_d = issued_q + CNT_W'(1);
          end
          if (remaining_q == CNT_W'(1)) begin
            state_d = StDone;
          end
        end else begin
          wd_clr = 1'b0;
          wd_inc = 1'b1;
          if (wd_expired) begin
            timeout_d = 1'b1;
            state_d   = StDone;
          end
        end
      end
      StDone: begin
        if (done_ready_i) begin
          state_d = StIdle;
        end
      end
      StFree: begin
        if (!free_run_i) begin
          state_d = StIdle;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      remaining_q <= '0;
      issued_q    <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      issued_q    <= issued_d;
      timeout_q   <= timeout_d;
    end
  end

  assign enable_issue_o = (state_q == StRun) || (state_q == StFree);
  assign done_valid_o   = (state_q == StDone);
  assign busy_o         = (state_q != StIdle);

  // Counters are frozen outside RUN, so the record is stable throughout DONE.
  assign done_rec.issued  = STEP_CNT_W_MAX'(issued_q);
  assign done_rec.timeout = timeout_q;
  assign done_issued_o    = done_rec.issued[CNT_W-1:0];
  assign done_timeout_o   = done_rec.timeout;
  assign unused_rec_hi    = ^(done_rec.issued >> CNT_W);

`ifdef CONTRACT_STEP_STATS_EN
  logic [63:0] total_q;
  logic        stray_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      total_q <= '0;
      stray_q <= 1'b0;
    end else if (issue_i) begin
      if (enable_issue_o) begin
        total_q <= total_q + 64'd1;
      end else begin
        stray_q <= 1'b1;
      end
    end
  end

  assign total_issued_o = total_q;
  assign stray_issue_o  = stray_q;
`else
  assign total_issued_o = '0;
  assign stray_issue_o  = 1'b0;
`endif

endmodule
